cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the cache datapath and its completion logic.
- Accepts read/write requests from two ports and serialises them onto the single cache re/we/addr/wdata interface.
- Issues one single-cycle operation strobe per request, then waits for the cache `done`.
- Returns read data, a hit flag and a one-cycle `ack` to the winning requester.

Parameters:
- ADDR_W, 8, cache address width
- DATA_W, 8, data word width
- TIMEOUT_CYCLES, 16, cycles in WAIT before forced abort (used only with the optional feature)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req  in  2  per-port request; held high until that port's ack
- req_we  in  2  per-port op: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  port p write data, same packing
- gnt  out  2  one-hot, high from grant until ack (inclusive)
- ack  out  2  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid in the ack cycle
- rsp_hit  out  1  cache hit flag for the completed op, valid in the ack cycle
- rsp_err  out  1  timeout flag, valid in the ack cycle
- re  out  1  cache read strobe
- we  out  1  cache write strobe
- addr  out  ADDR_W  cache address
- wdata  out  DATA_W  cache write data
- rdata  in  DATA_W  cache read data, valid with done
- hit  in  1  cache hit indication, valid with done
- done  in  1  cache operation complete, one-cycle pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE, gnt=0, ack=0, re=0, we=0, addr=0, wdata=0, rsp_rdata=0, rsp_hit=0, rsp_err=0, busy=0, last_grant=1. last_grant=1 means port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner: the single requester, or on a tie the port != last_grant.
  - Latch that port's we/addr/wdata into internal registers, set gnt[winner], go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly one cycle): re=~lat_we, we=lat_we, addr/wdata driven from the latched values; go to WAIT.
- WAIT:
  - re=we=0; addr/wdata stay held.
  - On done=1, capture rdata→rsp_rdata and hit→rsp_hit, clear rsp_err, go to RESP.
- RESP (one cycle):
  - ack[winner]=1; gnt stays high this cycle.
  - last_grant←winner; go to IDLE; gnt clears on exit.
- Minimum latency: req sampled high at edge N → re/we high in cycle N+1 → ack at cycle (done cycle)+1. The next grant is taken no earlier than the cycle after ack.
- Request capture: fields are latched at grant. Changes to req_addr/req_wdata/req_we after grant are ignored. Dropping req after grant does not abort the operation.
- Back-to-back: a port holding req after its ack is eligible again. If both ports request continuously, grants alternate 0,1,0,1…
- done asserted in IDLE, ISSUE or RESP is ignored and changes no outputs.
- rsp_rdata is updated for writes too (whatever the cache drives); requesters consume it only on reads.
- Reset mid-operation returns to IDLE immediately; any in-flight op is dropped with no ack.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES with no done, go to RESP with rsp_err=1, rsp_rdata=0, rsp_hit=0.
  - A done arriving in the same cycle as the timeout wins (normal completion, rsp_err=0).
- Without the macro: no counter exists, rsp_err is constant 0, and WAIT waits indefinitely for done.

Test Plan:
1. Reset with rst=0 for 5 cycles → all outputs 0, busy=0; release → idle, no strobes.
2. Port 0 read, addr=0x12; cache returns done 2 cycles after re with rdata=0xA5, hit=1 → re high exactly one cycle with addr=0x12, then ack=2'b01 with rsp_rdata=0xA5, rsp_hit=1, rsp_err=0.
3. Port 1 write, addr=0x34, wdata=0x5A, miss (done 3 cycles after we, hit=0) → we pulses once with wdata=0x5A, then ack=2'b10 with rsp_hit=0.
4. Both ports hold req for 4 transactions → grant order 0,1,0,1; only one gnt bit ever high; exactly one ack per grant.
5. Change req_addr during WAIT, and drive a spurious done while in IDLE → addr output unchanged; no ack from the spurious done.
6. With ARB_TIMEOUT_EN defined, never assert done → ack at cycle 16 of WAIT with rsp_err=1, rsp_rdata=0. Also assert rst mid-WAIT → immediate IDLE with no ack.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter that serialises read/write requests onto one cache port.
// Optional WAIT-state timeout abort is enabled by defining ARB_TIMEOUT_EN.
module cache_port_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_i,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          ack_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_hit_o,
    output logic                rsp_err_o,
    output logic                re_o,
    output logic                we_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                hit_i,
    input  logic                done_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_q, last_d;
    logic                lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                sel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       rsp_err_q, rsp_err_d;
`endif

    // On a tie the port that did not win last time is served.
    assign sel = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_hit_d   = rsp_hit_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    winner_d    = sel;
                    lat_we_d    = req_we_i[sel];
                    lat_addr_d  = sel ? req_addr_i[2*ADDR_W-1:ADDR_W]  : req_addr_i[ADDR_W-1:0];
                    lat_wdata_d = sel ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (done_i) begin
                    rsp_rdata_d = rdata_i;
                    rsp_hit_d   = hit_i;
`ifdef ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_hit_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                last_d  = winner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            winner_q    <= 1'b0;
            last_q      <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Cache address/data come straight from the latched request, so they hold through WAIT.
    assign busy_o      = (state_q != ST_IDLE);
    assign gnt_o       = busy_o ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    assign ack_o       = (state_q == ST_RESP) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    assign re_o        = (state_q == ST_ISSUE) && !lat_we_q;
    assign we_o        = (state_q == ST_ISSUE) && lat_we_q;
    assign addr_o      = lat_addr_q;
    assign wdata_o     = lat_wdata_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_hit_o   = rsp_hit_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed and random transactions against a
// behavioural round-robin model; define ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_cache_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    gnt, ack;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_hit, rsp_err, re, we, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          hit, done;

    int   checks   = 0;
    int   failures = 0;
    logic          last_grant;
    logic [DW-1:0] last_rdata;
    logic          last_hit;

    always #5 clk = ~clk;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .gnt_o(gnt), .ack_o(ack),
        .rsp_rdata_o(rsp_rdata), .rsp_hit_o(rsp_hit), .rsp_err_o(rsp_err),
        .re_o(re), .we_o(we), .addr_o(addr), .wdata_o(wdata), .rdata_i(rdata),
        .hit_i(hit), .done_i(done), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return last_grant ? 0 : 1;
        return r[1] ? 1 : 0;
    endfunction

    // Entry/exit: at a negedge with the DUT idle. done arrives `delay` cycles after the strobe.
    task automatic run_txn(input logic [1:0] r, input int delay, input logic [DW-1:0] rd, input logic h);
        int p;
        logic ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0] oh;
        p  = pick(r);
        oh = 2'(1 << p);
        ew = req_we[p];
        ea = req_addr[p*AW +: AW];
        ed = req_wdata[p*DW +: DW];
        req = r;
        @(negedge clk);
        chk("issue_re", re, !ew);
        chk("issue_we", we, ew);
        chk("issue_addr", addr, ea);
        if (ew) chk("issue_wdata", wdata, ed);
        chk("issue_gnt", gnt, oh);
        chk("issue_ack", ack, 2'b00);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_we    = 2'($urandom);
            chk("wait_strobe", {re, we}, 2'b00);
            chk("wait_addr", addr, ea);
            chk("wait_gnt", gnt, oh);
        end
        done  = 1'b1;
        rdata = rd;
        hit   = h;
        @(negedge clk);
        done  = 1'b0;
        rdata = DW'($urandom);
        chk("resp_ack", ack, oh);
        chk("resp_gnt", gnt, oh);
        chk("resp_rdata", rsp_rdata, rd);
        chk("resp_hit", rsp_hit, h);
        chk("resp_err", rsp_err, 1'b0);
        last_grant = p[0];
        last_rdata = rd;
        last_hit   = h;
        @(negedge clk);
        chk("post_ack", ack, 2'b00);
        chk("post_gnt", gnt, 2'b00);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [1:0] r;
        int k;
        rst_n = 1'b0; req = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        rdata = 0; hit = 0; done = 0;
        last_grant = 1'b1; last_rdata = 0; last_hit = 0;

        // reset
        repeat (5) @(negedge clk);
        chk("rst_outs", {gnt, ack, re, we, busy, rsp_hit, rsp_err}, 0);
        chk("rst_data", {addr, wdata, rsp_rdata}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outs", {gnt, ack, re, we, busy}, 0);

        // port 0 read hit
        req_we = 2'b00; req_addr = {8'h00, 8'h12};
        run_txn(2'b01, 2, 8'hA5, 1'b1);
        req = 0;

        // port 1 write miss
        req_we = 2'b10; req_addr = {8'h34, 8'h00}; req_wdata = {8'h5A, 8'h00};
        run_txn(2'b10, 3, 8'h3C, 1'b0);
        req = 0;

        // both ports hold req: alternating grants starting at 0
        for (int t = 0; t < 4; t++) begin
            req_we = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
            chk("rr_order", pick(2'b11), t % 2);
            run_txn(2'b11, $urandom_range(1, 3), DW'($urandom), 1'($urandom));
        end
        req = 0;

        // spurious done in IDLE
        done = 1'b1; rdata = ~last_rdata; hit = ~last_hit;
        @(negedge clk);
        done = 1'b0;
        chk("spur_ack", ack, 2'b00);
        chk("spur_busy", busy, 1'b0);
        chk("spur_rdata", rsp_rdata, last_rdata);
        chk("spur_hit", rsp_hit, last_hit);

        // random traffic
        for (int t = 0; t < 20; t++) begin
            r = 2'($urandom_range(1, 3));
            req_we = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
            run_txn(r, $urandom_range(1, 4), DW'($urandom), 1'($urandom));
        end
        req = 0;

        // reset in the middle of WAIT drops the op
        req_we = 2'b00; req_addr = {8'h00, 8'h77}; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_gnt", gnt, 2'b00);
        chk("mid_rst_rdata", rsp_rdata, 0);
        last_grant = 1'b1; last_rdata = 0; last_hit = 0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 0;
        rst_n = 1'b1;
        chk("rst_no_ack", ack, 2'b00);
        @(negedge clk);
        chk("after_rst_idle", {busy, ack}, 0);
        req_we = 0; req_addr = $urandom;
        run_txn(2'b11, 1, 8'h99, 1'b1);
        req = 0;

`ifdef ARB_TIMEOUT_EN
        // no done: abort after TO WAIT cycles, ack in the following cycle
        req_we = 2'b00; req_addr = $urandom; req = 2'b10;
        @(negedge clk);
        k = 0;
        for (int i = 1; i <= TO + 8; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin k = i; break; end
        end
        chk("to_cycle", k, TO + 1);
        chk("to_ack", ack, 2'b10);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_hit", rsp_hit, 1'b0);
        req = 0;
        @(negedge clk);
`else
        k = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
